// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way set-associative data cache.
// Address layout: [TAG | INDEX | word select | byte offset].
package cache_pkg;

    localparam int CACHE_SETS  = 64;
    localparam int CACHE_TAG_W = 10;
    localparam int WORD_BIT    = 2;
    localparam int IDX_LSB     = 3;
    localparam int WORD_W      = 32;
    localparam int BLOCK_W     = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    // Word 0 lives in the low half of a block.
    function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                      input logic sel);
        return sel ? blk[BLOCK_W-1:WORD_W] : blk[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid bits, tag and data arrays, and the hit compare.
// Only the valid bits are reset; tag/data contents are don't-care until filled.
module cache_way
    import cache_pkg::*;
#(
    parameter  int SETS  = CACHE_SETS,
    parameter  int TAG_W = CACHE_TAG_W,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   index,
    input  logic [TAG_W-1:0]   tag,
    input  logic               fill_en,
    input  logic [BLOCK_W-1:0] fill_data,
    input  logic               word_we,
    input  logic               word_sel,
    input  logic [WORD_W-1:0]  word_data,
    output logic               valid,
    output logic               hit,
    output logic [BLOCK_W-1:0] block
);

    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_mem  [SETS];
    logic [BLOCK_W-1:0] data_mem [SETS];

    assign valid = valid_q[index];
    assign hit   = valid && (tag_mem[index] == tag);
    assign block = data_mem[index];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= fill_data;
        end else if (word_we) begin
            if (word_sel) begin
                data_mem[index][BLOCK_W-1:WORD_W] <= word_data;
            end else begin
                data_mem[index][WORD_W-1:0] <= word_data;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate L1 data cache controller in the MEM stage.
// Handshake: ready=1 means the current request completes this cycle; ~ready freezes the pipeline.
module cache_controller
    import cache_pkg::*;
#(
    parameter  int SETS   = CACHE_SETS,
    parameter  int TAG_W  = CACHE_TAG_W,
    localparam int IDX_W  = $clog2(SETS),
    localparam int ADDR_W = TAG_W + IDX_W + IDX_LSB
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [WORD_W-1:0]  wdata,
    output logic [WORD_W-1:0]  rdata,
    output logic               ready,
    output logic               sram_rd_en,
    output logic               sram_wr_en,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [WORD_W-1:0]  sram_wdata,
    input  logic [BLOCK_W-1:0] sram_rdata,
    input  logic               sram_ready,
    output state_t             dbg_state
);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [SETS-1:0]     lru;
    logic                rd_q;
    logic                wr_q;

    logic [IDX_W-1:0]    lk_index;
    logic [TAG_W-1:0]    lk_tag;
    logic                lk_word;
    logic                valid0, valid1, hit0, hit1;
    logic [BLOCK_W-1:0]  block0, block1;
    logic                hit, hit_way, victim;
    logic                fill_en, word_we;

    // In IDLE the live request is looked up; while waiting, the latched one.
    assign lk_index = (state_q == IDLE) ? addr[IDX_LSB +: IDX_W]   : addr_q[IDX_LSB +: IDX_W];
    assign lk_tag   = (state_q == IDLE) ? addr[ADDR_W-1 -: TAG_W]  : addr_q[ADDR_W-1 -: TAG_W];
    assign lk_word  = (state_q == IDLE) ? addr[WORD_BIT]           : addr_q[WORD_BIT];

    assign hit     = hit0 | hit1;
    assign hit_way = ~hit0;
    assign victim  = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[lk_index]);
    assign fill_en = (state_q == RD_MISS) && sram_ready;
    assign word_we = (state_q == WR_WAIT) && sram_ready && hit;

    cache_way #(.SETS(SETS), .TAG_W(TAG_W)) u_way0 (
        .clk(clk), .rst(rst), .index(lk_index), .tag(lk_tag),
        .fill_en(fill_en && !victim), .fill_data(sram_rdata),
        .word_we(word_we && !hit_way), .word_sel(lk_word), .word_data(wdata_q),
        .valid(valid0), .hit(hit0), .block(block0)
    );

    cache_way #(.SETS(SETS), .TAG_W(TAG_W)) u_way1 (
        .clk(clk), .rst(rst), .index(lk_index), .tag(lk_tag),
        .fill_en(fill_en && victim), .fill_data(sram_rdata),
        .word_we(word_we && hit_way), .word_sel(lk_word), .word_data(wdata_q),
        .valid(valid1), .hit(hit1), .block(block1)
    );

    // Store wins over load when both are raised.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            lru     <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        state_q <= WR_WAIT;
                        wr_q    <= 1'b1;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                    end else if (rd_en) begin
                        if (hit) begin
                            lru[lk_index] <= ~hit_way;
                        end else begin
                            state_q <= RD_MISS;
                            rd_q    <= 1'b1;
                            addr_q  <= addr;
                        end
                    end
                end
                RD_MISS: begin
                    if (sram_ready) begin
                        state_q       <= IDLE;
                        rd_q          <= 1'b0;
                        lru[lk_index] <= ~victim;
                    end
                end
                WR_WAIT: begin
                    if (sram_ready) begin
                        state_q <= IDLE;
                        wr_q    <= 1'b0;
                        if (hit) begin
                            lru[lk_index] <= ~hit_way;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ready = 1'b1;
        rdata = '0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        ready = 1'b0;
                    end else if (rd_en) begin
                        if (hit) begin
                            rdata = block_word(hit_way ? block1 : block0, lk_word);
                        end else begin
                            ready = 1'b0;
                        end
                    end
                end
                RD_MISS: begin
                    ready = sram_ready;
                    if (sram_ready) begin
                        rdata = block_word(sram_rdata, lk_word);
                    end
                end
                WR_WAIT: ready = sram_ready;
                default: ready = 1'b1;
            endcase
        end
    end

    assign sram_rd_en = rd_q;
    assign sram_wr_en = wr_q;
    assign sram_addr  = rd_q ? {addr_q[ADDR_W-1:IDX_LSB], 3'b000} : addr_q;
    assign sram_wdata = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter SETS, 64, number of sets; SHALL be a power of two.
REQ-002 Parameter TAG_W, 10, tag width; address width SHALL be TAG_W+log2(SETS)+3.
REQ-003 clk  in  1  pipeline clock, shared with the MEM stage.
REQ-004 rst  in  1  reset; asynchronous, active-low.
REQ-005 rd_en  in  1  MEM-stage load request.
REQ-006 wr_en  in  1  MEM-stage store request.
REQ-007 addr  in  19  byte address: [2] word select, [8:3] index, [18:9] tag.
REQ-008 wdata  in  32  store data.
REQ-009 rdata  out  32  load data, valid when ready=1 and rd_en=1.
REQ-010 ready  out  1  request complete; pipeline freeze = ~ready.
REQ-011 sram_rd_en / sram_wr_en  out  1 each  SRAM-controller strobes.
REQ-012 sram_addr  out  19  address to SRAM controller.
REQ-013 sram_wdata  out  32  store data to SRAM controller.
REQ-014 sram_rdata  in  64  block (two words, word0 in [31:0]) from SRAM controller.
REQ-015 sram_ready  in  1  SRAM transaction done, one-cycle pulse.

Function
REQ-016 Organisation: 2-way set associative, SETS sets, 64-bit block per way, per-set valid[1:0], tag[1:0], lru bit.
REQ-017 lru SHALL name the way to replace next; any access hitting/filling way w SHALL set lru=~w.
REQ-018 States IDLE, RD_MISS, WR_WAIT; held in an enum.
REQ-019 IDLE, rd_en=1, hit: rdata = selected word, ready=1 same cycle (combinational); no SRAM strobe; stay IDLE.
REQ-020 IDLE, rd_en=1, miss: ready=0, latch addr, assert sram_rd_en with sram_addr={tag,index,3'b000}, go RD_MISS.
REQ-021 RD_MISS: hold strobes/address until sram_ready=1; on that cycle write sram_rdata into victim way, set valid, tag, lru; rdata = word[addr[2]] of sram_rdata; ready=1; go IDLE.
REQ-022 Victim: way0 if invalid, else way1 if invalid, else way lru.
REQ-023 Writes: write-through, no-write-allocate; IDLE, wr_en=1: ready=0, latch addr/wdata, assert sram_wr_en, go WR_WAIT.
REQ-024 WR_WAIT: on sram_ready=1, if latched addr hits, update that word and lru; on miss no cache change; ready=1; go IDLE.
REQ-025 rd_en=wr_en=0: ready=1, no strobes, no state change.
REQ-026 rd_en=wr_en=1: protocol error; wr_en SHALL take priority.
REQ-027 Inputs changing during RD_MISS/WR_WAIT SHALL be ignored; latched values govern.
REQ-028 sram_ready asserted in IDLE SHALL be ignored.
REQ-029 sram_rd_en and sram_wr_en SHALL never be high together.

Reset
REQ-030 rst low: state=IDLE, all valid and lru bits cleared, strobes=0, ready=1, rdata=0; takes effect immediately, including mid-miss or mid-write.
REQ-031 Tag/data arrays need not reset.

Structure
REQ-032 Package cache_pkg: state enum, SETS, TAG_W, address field positions, block width.
REQ-033 One sub-module cache_way (tag, valid, data array for one way with hit compare), instantiated twice; controller holds FSM and lru.

Verification
REQ-034 Cold read 0x00040 -> ready=0, sram_rd_en=1, sram_addr=0x00040; sram_ready with sram_rdata=0x22222222_11111111 -> rdata=0x11111111, ready=1.
REQ-035 Then read 0x00044 -> hit, rdata=0x22222222, ready=1 same cycle, no SRAM strobe.
REQ-036 Fill index 8 with tags 0x001, 0x002, read tag 0x001, then miss tag 0x003 -> replaces tag 0x002 way; re-read tag 0x001 hits.
REQ-037 Write 0xDEADBEEF to cached 0x00040 -> sram_wr_en until sram_ready; subsequent read 0x00040 hits with 0xDEADBEEF; write to uncached address leaves it a miss.
REQ-038 rst low two cycles into RD_MISS -> strobes drop immediately, ready=1; prior cached address then misses.
REQ-039 rd_en=wr_en=1 -> only sram_wr_en asserted; addr toggled during WR_WAIT -> sram_addr unchanged.
